// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bundle: fetch push side, decode pop side, flush and occupancy.
// Latency: none, wiring only. Backpressure: f_ready from the queue, d_ready from decode.
// Modports: master = fetch/decode environment, slave = the queue itself.
interface fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              f_valid;
    logic [DATA_W-1:0] f_pc;
    logic [DATA_W-1:0] f_inst;
    logic              f_ready;
    logic              d_ready;
    logic              d_valid;
    logic [DATA_W-1:0] d_pc;
    logic [DATA_W-1:0] d_inst;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, f_valid, f_pc, f_inst, d_ready,
        input  f_ready, d_valid, d_pc, d_inst, count
    );

    modport slave (
        input  flush, f_valid, f_pc, f_inst, d_ready,
        output f_ready, d_valid, d_pc, d_inst, count
    );
endinterface

// File: rtl/fetch_queue.sv
// First-word-fall-through fetch queue between fetch and decode; flush drops all entries.
// Latency: 1 cycle push to head (0 with FETCH_QUEUE_BYPASS_EN defined and queue empty).
// Backpressure: f_ready = (count < DEPTH) from registered state only; no push while full.
module fetch_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic          f_clk,
    input  logic          rst,
    fetch_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;

    logic empty;
    logic byp;
    logic push;
    logic pop;

    assign empty = (cnt == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue hands the fetched entry straight to decode when decode takes it now.
    assign byp = empty && q.f_valid && q.d_ready && !q.flush;
`else
    assign byp = 1'b0;
`endif

    assign q.f_ready = (cnt < CNT_W'(DEPTH));
    assign push      = q.f_valid && q.f_ready && !q.flush && !byp;
    assign pop       = !empty && q.d_ready && !q.flush;
    assign q.count   = cnt;

    always_comb begin
        q.d_valid = 1'b0;
        q.d_pc    = '0;
        q.d_inst  = '0;
        if (!empty) begin
            q.d_valid = 1'b1;
            q.d_pc    = pc_mem[rd_ptr];
            q.d_inst  = inst_mem[rd_ptr];
        end else if (byp) begin
            q.d_valid = 1'b1;
            q.d_pc    = q.f_pc;
            q.d_inst  = q.f_inst;
        end
    end

    // Storage is deliberately not reset; cnt gates every read of it.
    always_ff @(posedge f_clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= q.f_pc;
            inst_mem[wr_ptr] <= q.f_inst;
        end
    end

    always_ff @(posedge f_clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a reference scoreboard of queued entries.
module tb_fetch_queue;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic f_clk = 1'b0;
    logic rst;
    always #5 f_clk = ~f_clk;

    fetch_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .f_clk (f_clk),
        .rst   (rst),
        .q     (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   mcount = 0;
    ent_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the head against the scoreboard, advance, check count.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic dr, input logic fl);
        logic push_m, pop_m, byp_m;
        ent_t e;
        bus.f_valid = fv;
        bus.f_pc    = pc;
        bus.f_inst  = inst;
        bus.d_ready = dr;
        bus.flush   = fl;
        #1;
        byp_m = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp_m = (mcount == 0) && fv && dr && !fl;
`endif
        push_m = fv && (mcount < DEPTH) && !fl && !byp_m;
        pop_m  = (mcount > 0) && dr && !fl;
        chk("f_ready", 32'(bus.f_ready), 32'(mcount < DEPTH));
        if (byp_m) begin
            chk("byp_vld",  32'(bus.d_valid), 32'd1);
            chk("byp_pc",   bus.d_pc, pc);
            chk("byp_inst", bus.d_inst, inst);
        end else if (mcount == 0) begin
            chk("empty_vld",  32'(bus.d_valid), 32'd0);
            chk("empty_pc",   bus.d_pc, 32'd0);
            chk("empty_inst", bus.d_inst, 32'd0);
        end else begin
            e = sb[0];
            chk("head_vld",  32'(bus.d_valid), 32'd1);
            chk("head_pc",   bus.d_pc, e.pc);
            chk("head_inst", bus.d_inst, e.inst);
        end
        if (pop_m) e = sb.pop_front();
        if (push_m) sb.push_back(ent_t'({pc, inst}));
        if (fl) begin
            sb.delete();
            mcount = 0;
        end else begin
            mcount = mcount + int'(push_m) - int'(pop_m);
        end
        @(posedge f_clk);
        #1;
        chk("count", 32'(bus.count), 32'(mcount));
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h2000_0000 ^ (pc << 4);
    endfunction

    initial begin
        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.f_valid = 1'b0;
        bus.f_pc    = '0;
        bus.f_inst  = '0;
        bus.d_ready = 1'b0;
        #2;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_dvld",  32'(bus.d_valid), 32'd0);
        chk("rst_dpc",   bus.d_pc, 32'd0);
        chk("rst_dinst", bus.d_inst, 32'd0);
        chk("rst_frdy",  32'(bus.f_ready), 32'd1);
        @(posedge f_clk);
        @(posedge f_clk);
        #1 rst = 1'b0;

        // Two pushes with decode stalled
        step(1'b1, 32'd4, 32'h200a0005, 1'b0, 1'b0);
        step(1'b1, 32'd8, 32'h200b0007, 1'b0, 1'b0);
        chk("two_pc",   bus.d_pc, 32'd4);
        chk("two_inst", bus.d_inst, 32'h200a0005);

        // Fill to full, fifth push rejected, then drain in order
        step(1'b1, 32'd12, inst_of(32'd12), 1'b0, 1'b0);
        step(1'b1, 32'd16, inst_of(32'd16), 1'b0, 1'b0);
        chk("full_frdy", 32'(bus.f_ready), 32'd0);
        step(1'b1, 32'd20, inst_of(32'd20), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drained_inst", bus.d_inst, 32'd0);

        // Steady push+pop at count 2; pointers wrap several times
        step(1'b1, 32'd100, inst_of(32'd100), 1'b0, 1'b0);
        step(1'b1, 32'd104, inst_of(32'd104), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'd108 + 32'(4 * i), inst_of(32'd108 + 32'(4 * i)), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush at count 3 with a simultaneous push
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h300 + 32'(4 * i), inst_of(32'h300 + 32'(4 * i)), 1'b0, 1'b0);
        step(1'b1, 32'h500, inst_of(32'h500), 1'b1, 1'b1);
        chk("flush_vld", 32'(bus.d_valid), 32'd0);
        step(1'b0, '0, '0, 1'b0, 1'b0);

        // Empty queue, fetch and decode both active
        step(1'b1, 32'h600, 32'h014b5020, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges with count 3
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h700 + 32'(4 * i), inst_of(32'h700 + 32'(4 * i)), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_dvld",  32'(bus.d_valid), 32'd0);
        chk("arst_frdy",  32'(bus.f_ready), 32'd1);
        chk("arst_dinst", bus.d_inst, 32'd0);
        #1 rst = 1'b0;
        sb.delete();
        mcount = 0;
        step(1'b1, 32'h800, inst_of(32'h800), 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
